// File: rtl/q2_ctrl_pkg.sv
// Shared types and defaults for the q2 FSM input arbiter.
// The symbol type matches the 2-bit in/out ports of the downstream q2 FSM.
package q2_ctrl_pkg;

    typedef logic [1:0] sym_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StBurst  = 2'd1,
        StSettle = 2'd2
    } arb_state_t;

    // Symbol presented to the FSM whenever no requester transfer is happening.
    localparam sym_t DEFAULT_IDLE_SYM = 2'b00;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first asserted request found
// by searching upward from last_grant+1 with wrap-around.
module rr_pick #(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_grant,
    output logic                     valid,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        // Offset 1 first so the previous owner has lowest priority.
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((32'(last_grant) + i) % N_REQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/q2_input_arbiter.sv
// Round-robin arbiter sharing the 2-bit symbol input of a q2 Moore FSM between requesters.
// Grants one burst at a time, waits one settle cycle, then reports the FSM output reached.
module q2_input_arbiter
    import q2_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned MAX_BURST = 4,
    parameter sym_t        IDLE_SYM  = DEFAULT_IDLE_SYM
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [2*N_REQ-1:0]       req_sym,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output sym_t                     fsm_in,
    input  sym_t                     fsm_out,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(N_REQ)-1:0] done_id,
    output sym_t                     result
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_REQ = IDX_W'(N_REQ - 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [CNT_W-1:0] count_q, count_d;
    sym_t             result_q, result_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] done_id_q, done_id_d;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             owner_valid;
    logic             owner_last;
    sym_t             owner_sym;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

    assign owner_valid = req_valid[owner_q];
    assign owner_last  = req_last[owner_q];
    assign owner_sym   = sym_t'(req_sym >> (2 * owner_q));

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        count_d      = count_q;
        result_d     = result_q;
        done_d       = 1'b0;
        done_id_d    = done_id_q;
        req_ready    = '0;
        fsm_in       = IDLE_SYM;
        busy         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    owner_d      = pick_idx;
                    last_grant_d = pick_idx;
                    count_d      = '0;
                    state_d      = StBurst;
                end
            end
            StBurst: begin
                busy               = 1'b1;
                req_ready[owner_q] = 1'b1;
                // A missing symbol is a bubble: FSM sees IDLE_SYM, count holds.
                if (owner_valid) begin
                    fsm_in  = owner_sym;
                    count_d = count_q + 1'b1;
                    if (owner_last || count_q == CNT_LAST) begin
                        state_d = StSettle;
                    end
                end
            end
            StSettle: begin
                busy      = 1'b1;
                result_d  = fsm_out;
                done_d    = 1'b1;
                done_id_d = owner_q;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            owner_q      <= '0;
            last_grant_q <= LAST_REQ;
            count_q      <= '0;
            result_q     <= '0;
            done_q       <= 1'b0;
            done_id_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
            result_q     <= result_d;
            done_q       <= done_d;
            done_id_q    <= done_id_d;
        end
    end

    assign grant_id = owner_q;
    assign done     = done_q;
    assign done_id  = done_id_q;
    assign result   = result_q;

    ready_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(req_ready));

endmodule
